// File: rtl/adder_field_sequencer.sv
// Word-cycle sequencer for the bit-serial BCD adder/subtractor: T1..T4 bit states, digit counter,
// per-word request handling, field qualification and carry capture.
module adder_field_sequencer #(
  parameter int DIGITS = 14
) (
  input  logic       phi2,
  input  logic       reset,
  input  logic       start,
  input  logic       req_sub,
  input  logic       req_cin,
  input  logic [3:0] field_first,
  input  logic [3:0] field_last,
  input  logic       add_carry,
  output logic       t1,
  output logic       t2,
  output logic       t3,
  output logic       t4,
  output logic [3:0] digit,
  output logic       sync,
  output logic       busy,
  output logic       in_field,
  output logic       first_bit,
  output logic       sub,
  output logic       c_in,
  output logic       carry_flag,
  output logic       done,
  output logic       err
);

  localparam logic [3:0] LAST_DIGIT = 4'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RUN} state_t;

  state_t     state, state_n;
  logic [3:0] t_q;
  logic       sub_q, cin_q;
  logic [3:0] first_q, last_q;
  logic       word_end, field_ok, accept;

  assign word_end = t_q[3] && (digit == LAST_DIGIT);
  assign field_ok = (field_first <= field_last) && (field_last <= LAST_DIGIT);
  assign accept   = (state == IDLE) && start && field_ok;

  // Free-running timing chain; only reset disturbs it.
  always_ff @(posedge phi2) begin
    if (reset) begin
      t_q   <= 4'b0001;
      digit <= 4'd0;
    end else begin
      t_q <= {t_q[2:0], t_q[3]};
      if (t_q[3]) begin
        digit <= word_end ? 4'd0 : digit + 4'd1;
      end
    end
  end

  always_ff @(posedge phi2) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // A request arriving on the last bit of a word skips WAIT so RUN still starts at DIGIT=0,T1.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = word_end ? RUN : WAIT;
      WAIT: if (word_end) state_n = RUN;
      RUN:  if (word_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge phi2) begin
    if (reset) begin
      sub_q   <= 1'b0;
      cin_q   <= 1'b0;
      first_q <= 4'd0;
      last_q  <= 4'd0;
    end else if (accept) begin
      sub_q   <= req_sub;
      cin_q   <= req_cin;
      first_q <= field_first;
      last_q  <= field_last;
    end
  end

  always_ff @(posedge phi2) begin
    if (reset) begin
      carry_flag <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      if ((state == RUN) && t_q[3] && (digit == last_q)) begin
        carry_flag <= add_carry;
      end
      done <= (state == RUN) && word_end;
      err  <= (state == IDLE) && start && !field_ok;
    end
  end

  // Decoded purely from registers so no input reaches an output combinationally.
  always_comb begin
    t1        = t_q[0];
    t2        = t_q[1];
    t3        = t_q[2];
    t4        = t_q[3];
    sync      = t_q[0] && (digit == 4'd0);
    busy      = (state != IDLE);
    in_field  = (state == RUN) && (digit >= first_q) && (digit <= last_q);
    first_bit = in_field && t_q[0] && (digit == first_q);
    sub       = busy && sub_q;
    c_in      = busy && cin_q;
  end

endmodule
